// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents: fetch FSM state enum, default memory depth, instruction and
// address widths.
package pacote_busca;

  typedef enum logic [1:0] {
    BUSCA  = 2'd0,  // fetching one word per cycle
    ESPERA = 2'd1,  // output valid, decode not ready
    FIM    = 2'd2   // PC outside the populated range, fetch stopped
  } estado_t;

  localparam int MEM_WORDS_PADRAO = 64;
  localparam int LARG_INSTR       = 32;
  localparam int LARG_END         = 64;

endpackage

// File: rtl/unidade_busca_contador.sv
// Performance counters for the fetch unit.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   transferencia     - an instruction was handed to decode this cycle
//   bolha             - output stage empty outside FIM this cycle
//   cont_instrucoes   - running count of transfers (wraps at 2^32)
//   cont_bolhas       - running count of bubble cycles (wraps at 2^32)
module contador_busca (
  input  logic        clk,
  input  logic        reset,
  input  logic        transferencia,
  input  logic        bolha,
  output logic [31:0] cont_instrucoes,
  output logic [31:0] cont_bolhas
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cont_instrucoes <= '0;
      cont_bolhas     <= '0;
    end else begin
      if (transferencia) cont_instrucoes <= cont_instrucoes + 32'd1;
      if (bolha)         cont_bolhas     <= cont_bolhas + 32'd1;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: owns the PC, addresses the instruction ROM,
// registers the returned word and hands it to decode via valid/ready.
// Redirect flushes the output stage and has priority over everything
// except reset. Fetch stops (state FIM) once the PC leaves [0, MEM_WORDS).
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   pc_mem        [63:0]  out       - word address to ROM (the PC register)
//   instrucao_mem [31:0]  in        - ROM data for pc_mem, same cycle
//   desvio_valido / desvio_alvo in  - redirect request and target
//   saida_valida / saida_pronta     - output handshake to decode
//   saida_instrucao, saida_pc out   - registered instruction and its address
//   fim_memoria   out               - high while fetch is stopped (FIM)
//   cont_instrucoes, cont_bolhas    - performance counters, present only
//                                     when BUSCA_CONTADOR_EN is defined
module unidade_busca
  import pacote_busca::*;
#(
  parameter logic [LARG_END-1:0] PC_RESET  = '0,
  parameter int                  MEM_WORDS = MEM_WORDS_PADRAO
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [LARG_END-1:0]   pc_mem,
  input  logic [LARG_INSTR-1:0] instrucao_mem,
  input  logic                  desvio_valido,
  input  logic [LARG_END-1:0]   desvio_alvo,
  output logic                  saida_valida,
  input  logic                  saida_pronta,
  output logic [LARG_INSTR-1:0] saida_instrucao,
  output logic [LARG_END-1:0]   saida_pc,
  output logic                  fim_memoria
`ifdef BUSCA_CONTADOR_EN
  ,
  output logic [31:0]           cont_instrucoes,
  output logic [31:0]           cont_bolhas
`endif
);

  localparam logic [LARG_END-1:0] LIMITE = LARG_END'(MEM_WORDS);

  estado_t             estado, estado_prox;
  logic [LARG_END-1:0] pc;
  logic                livre, em_faixa, carregar;

  assign pc_mem   = pc;
  assign livre    = !saida_valida || saida_pronta;
  assign em_faixa = pc < LIMITE;

  // State register
  always_ff @(posedge clk) begin
    if (reset) estado <= BUSCA;
    else       estado <= estado_prox;
  end

  // Next state
  always_comb begin
    estado_prox = estado;
    if (desvio_valido) begin
      estado_prox = BUSCA;
    end else if (estado != FIM) begin
      if (!livre)        estado_prox = ESPERA;
      else if (em_faixa) estado_prox = BUSCA;
      else               estado_prox = FIM;
    end
  end

  // Outputs / datapath control
  always_comb begin
    carregar    = !desvio_valido && (estado != FIM) && livre && em_faixa;
    fim_memoria = (estado == FIM);
  end

  // PC and output stage. A word fetched during a redirect cycle is dropped;
  // the word being transferred that cycle still counts as accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= PC_RESET;
      saida_valida    <= 1'b0;
      saida_instrucao <= '0;
      saida_pc        <= '0;
    end else if (desvio_valido) begin
      pc           <= desvio_alvo;
      saida_valida <= 1'b0;
    end else if (carregar) begin
      saida_instrucao <= instrucao_mem;
      saida_pc        <= pc;
      saida_valida    <= 1'b1;
      pc              <= pc + 64'd1;
    end else if (livre) begin
      // free but nothing to load: out of range (or already in FIM)
      saida_valida <= 1'b0;
    end
  end

`ifdef BUSCA_CONTADOR_EN
  contador_busca u_contador (
    .clk             (clk),
    .reset           (reset),
    .transferencia   (saida_valida && saida_pronta),
    .bolha           (!saida_valida && (estado != FIM)),
    .cont_instrucoes (cont_instrucoes),
    .cont_bolhas     (cont_bolhas)
  );
`endif

endmodule
